// File: rtl/xc_malu_pkg.sv
// Shared encodings for the xc_malu issuer: opcodes, pack-width one-hots,
// issuer FSM states and the largest legal packed-width select.
package xc_malu_pkg;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_PMUL = 3'd1,
    OP_DIV  = 3'd2,
    OP_REM  = 3'd3,
    OP_MACC = 3'd4,
    OP_MADD = 3'd5,
    OP_MSUB = 3'd6
  } malu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issuer_state_e;

  localparam logic [2:0] PW_SINGLE_MAX = 3'd4;

  // Select 0 is the widest lane split and lands in the MSB of malu_pw.
  localparam logic [4:0] PW_SEL_0 = 5'b10000;
  localparam logic [4:0] PW_SEL_1 = 5'b01000;
  localparam logic [4:0] PW_SEL_2 = 5'b00100;
  localparam logic [4:0] PW_SEL_3 = 5'b00010;
  localparam logic [4:0] PW_SEL_4 = 5'b00001;
  localparam logic [4:0] PW_WORD  = 5'b00001;

  function automatic logic [4:0] pw_onehot(input logic [2:0] pw_single);
    case (pw_single)
      3'd0:    pw_onehot = PW_SEL_0;
      3'd1:    pw_onehot = PW_SEL_1;
      3'd2:    pw_onehot = PW_SEL_2;
      3'd3:    pw_onehot = PW_SEL_3;
      3'd4:    pw_onehot = PW_SEL_4;
      default: pw_onehot = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/xc_malu_rsp_buf.sv
// One-entry valid/ready response register holding {err, tag, hi, lo}.
// A drain and a fill may happen in the same cycle.
module xc_malu_rsp_buf #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fill,
  input  logic             fill_err,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_hi,
  input  logic [31:0]      fill_lo,
  output logic             full,
  output logic             accept,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_hi,
  output logic [31:0]      rsp_lo
);

  assign full   = rsp_valid;
  assign accept = !rsp_valid || rsp_ready;

  // The writer only pulses fill while accept is high, so a full entry is never overwritten.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
      rsp_hi    <= '0;
      rsp_lo    <= '0;
    end else if (fill) begin
      rsp_valid <= 1'b1;
      rsp_err   <= fill_err;
      rsp_tag   <= fill_tag;
      rsp_hi    <= fill_hi;
      rsp_lo    <= fill_lo;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/xc_malu_issuer.sv
// Initiator side of the xc_malu valid/ready/flush port with a one-entry response buffer.
// Define XC_MALU_ISSUER_TIMEOUT_EN to add the ISSUE-state watchdog.
module xc_malu_issuer
  import xc_malu_pkg::*;
#(
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [31:0]      req_rs3,
  input  logic [2:0]       req_pw_single,
  input  logic             req_lhs_sign,
  input  logic             req_rhs_sign,
  input  logic             req_drem_unsigned,
  input  logic             req_carryless,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_kill,
  output logic             malu_valid,
  input  logic             malu_ready,
  output logic             malu_flush,
  output logic [31:0]      malu_rs1,
  output logic [31:0]      malu_rs2,
  output logic [31:0]      malu_rs3,
  output logic             malu_insn_mul,
  output logic             malu_insn_pmul,
  output logic             malu_insn_div,
  output logic             malu_insn_rem,
  output logic             malu_insn_macc,
  output logic             malu_insn_madd,
  output logic             malu_insn_msub,
  output logic [4:0]       malu_pw,
  output logic             malu_lhs_sign,
  output logic             malu_rhs_sign,
  output logic             malu_drem_unsigned,
  output logic             malu_carryless,
  input  logic [31:0]      malu_result_1,
  input  logic [31:0]      malu_result_0,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_hi,
  output logic [31:0]      rsp_lo,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output issuer_state_e    state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and the payload holds steady while valid is high and ready is low.

  issuer_state_e    state;
  logic [TAG_W-1:0] tag_q;
  logic             issuing, req_illegal, accept, complete, timeout_fire, carryless_d;
  logic             buf_full, buf_accept, buf_fill;

  assign issuing     = (state == ST_ISSUE);
  assign req_illegal = (req_op == OP_PMUL) && (req_pw_single > PW_SINGLE_MAX);
  assign req_ready   = !issuing && (!req_illegal || buf_accept);
  assign accept      = req_valid && req_ready;
  assign complete    = issuing && malu_ready && buf_accept && !req_kill;
  assign carryless_d = req_carryless && ((req_op == OP_MUL) || (req_op == OP_PMUL));

`ifdef XC_MALU_ISSUER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt;
  logic             to_limit;

  assign to_limit = (to_cnt == TO_LAST);
  // The counter saturates at the limit so a blocked buffer just delays the error response.
  assign timeout_fire = issuing && to_limit && buf_accept && !req_kill && !complete;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (issuing && !to_limit) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  assign malu_valid = issuing;
  assign malu_flush = issuing && (req_kill || complete || timeout_fire);
  assign buf_fill   = (accept && req_illegal) || complete || timeout_fire;
  assign state_dbg  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      tag_q              <= '0;
      malu_rs1           <= '0;
      malu_rs2           <= '0;
      malu_rs3           <= '0;
      malu_insn_mul      <= 1'b0;
      malu_insn_pmul     <= 1'b0;
      malu_insn_div      <= 1'b0;
      malu_insn_rem      <= 1'b0;
      malu_insn_macc     <= 1'b0;
      malu_insn_madd     <= 1'b0;
      malu_insn_msub     <= 1'b0;
      malu_pw            <= '0;
      malu_lhs_sign      <= 1'b0;
      malu_rhs_sign      <= 1'b0;
      malu_drem_unsigned <= 1'b0;
      malu_carryless     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !req_illegal) begin
            state              <= ST_ISSUE;
            tag_q              <= req_tag;
            malu_rs1           <= req_rs1;
            malu_rs2           <= req_rs2;
            malu_rs3           <= req_rs3;
            malu_insn_mul      <= (req_op == OP_MUL);
            malu_insn_pmul     <= (req_op == OP_PMUL);
            malu_insn_div      <= (req_op == OP_DIV);
            malu_insn_rem      <= (req_op == OP_REM);
            malu_insn_macc     <= (req_op == OP_MACC);
            malu_insn_madd     <= (req_op == OP_MADD);
            malu_insn_msub     <= (req_op == OP_MSUB);
            malu_pw            <= (req_op == OP_PMUL) ? pw_onehot(req_pw_single) : PW_WORD;
            malu_lhs_sign      <= req_lhs_sign && !carryless_d;
            malu_rhs_sign      <= req_rhs_sign && !carryless_d;
            malu_drem_unsigned <= req_drem_unsigned;
            malu_carryless     <= carryless_d;
          end
        end
        ST_ISSUE: begin
          if (malu_flush) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  xc_malu_rsp_buf #(.TAG_W(TAG_W)) u_rsp_buf (
    .clock     (clock),
    .reset     (reset),
    .fill      (buf_fill),
    .fill_err  (!complete),
    .fill_tag  (issuing ? tag_q : req_tag),
    .fill_hi   (complete ? malu_result_1 : 32'd0),
    .fill_lo   (complete ? malu_result_0 : 32'd0),
    .full      (buf_full),
    .accept    (buf_accept),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .rsp_tag   (rsp_tag),
    .rsp_hi    (rsp_hi),
    .rsp_lo    (rsp_lo)
  );

endmodule

// File: tb/tb_xc_malu_issuer.sv
// Directed bench for xc_malu_issuer: a per-cycle model/scoreboard plus literal
// expectations. The watchdog case is built only with XC_MALU_ISSUER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_xc_malu_issuer;
  import xc_malu_pkg::*;

  localparam int TAG_W          = 5;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int RW             = 1 + TAG_W + 64;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic             req_valid = 0, req_kill = 0, malu_ready = 0, rsp_ready = 1;
  logic [2:0]       req_op = '0, req_pw_single = '0;
  logic [31:0]      req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic             req_lhs_sign = 0, req_rhs_sign = 0, req_drem_unsigned = 0, req_carryless = 0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      malu_result_1 = '0, malu_result_0 = '0;
  logic             req_ready, malu_valid, malu_flush, rsp_valid, rsp_err;
  logic [31:0]      malu_rs1, malu_rs2, malu_rs3, rsp_hi, rsp_lo;
  logic             malu_insn_mul, malu_insn_pmul, malu_insn_div, malu_insn_rem;
  logic             malu_insn_macc, malu_insn_madd, malu_insn_msub;
  logic [4:0]       malu_pw;
  logic             malu_lhs_sign, malu_rhs_sign, malu_drem_unsigned, malu_carryless;
  logic [TAG_W-1:0] rsp_tag;
  issuer_state_e    state_dbg;

  xc_malu_issuer #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .req_pw_single(req_pw_single), .req_lhs_sign(req_lhs_sign), .req_rhs_sign(req_rhs_sign),
    .req_drem_unsigned(req_drem_unsigned), .req_carryless(req_carryless),
    .req_tag(req_tag), .req_kill(req_kill),
    .malu_valid(malu_valid), .malu_ready(malu_ready), .malu_flush(malu_flush),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_insn_mul(malu_insn_mul), .malu_insn_pmul(malu_insn_pmul), .malu_insn_div(malu_insn_div),
    .malu_insn_rem(malu_insn_rem), .malu_insn_macc(malu_insn_macc), .malu_insn_madd(malu_insn_madd),
    .malu_insn_msub(malu_insn_msub), .malu_pw(malu_pw),
    .malu_lhs_sign(malu_lhs_sign), .malu_rhs_sign(malu_rhs_sign),
    .malu_drem_unsigned(malu_drem_unsigned), .malu_carryless(malu_carryless),
    .malu_result_1(malu_result_1), .malu_result_0(malu_result_0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .state_dbg(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [RW-1:0]    exp_q[$];
  logic             m_busy = 1'b0;
  logic [31:0]      m_rs1, m_rs2, m_rs3;
  logic [6:0]       m_insn;
  logic [4:0]       m_pw;
  logic             m_lhs, m_rhs, m_drem, m_cl;
  logic [TAG_W-1:0] m_tag;
  int               m_cnt = 0;
  int               flush_cnt = 0;
  int               rsp_cnt = 0;
  logic [RW-1:0]    last_rsp = '0;

  always @(negedge clock) begin : cmp
    logic buf_free, illegal, e_ready, done, tmo, acc;
    if (reset) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else begin
      buf_free = (exp_q.size() == 0) || rsp_ready;
      illegal  = (req_op == 3'd1) && (req_pw_single > 3'd4);
      e_ready  = !m_busy && (!illegal || buf_free);
      done     = m_busy && malu_ready && buf_free && !req_kill;
      tmo      = 1'b0;
`ifdef XC_MALU_ISSUER_TIMEOUT_EN
      tmo = m_busy && !done && !req_kill && buf_free && (m_cnt >= TIMEOUT_CYCLES - 1);
`endif
      check("req_ready", 128'(req_ready), 128'(e_ready));
      check("malu_valid", 128'(malu_valid), 128'(m_busy));
      check("malu_flush", 128'(malu_flush), 128'(m_busy && (req_kill || done || tmo)));
      check("rsp_valid", 128'(rsp_valid), 128'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        check("rsp_data", 128'({rsp_err, rsp_tag, rsp_hi, rsp_lo}), 128'(exp_q[0]));
      if (m_busy) begin
        check("malu_operands", 128'({malu_rs1, malu_rs2, malu_rs3}), 128'({m_rs1, m_rs2, m_rs3}));
        check("malu_controls",
              128'({malu_insn_mul, malu_insn_pmul, malu_insn_div, malu_insn_rem, malu_insn_macc,
                    malu_insn_madd, malu_insn_msub, malu_pw, malu_lhs_sign, malu_rhs_sign,
                    malu_drem_unsigned, malu_carryless}),
              128'({m_insn, m_pw, m_lhs, m_rhs, m_drem, m_cl}));
      end
      if (malu_flush) flush_cnt++;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        last_rsp = {rsp_err, rsp_tag, rsp_hi, rsp_lo};
      end
      // advance the model to the state the coming rising edge produces
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      acc = req_valid && e_ready;
      if (acc && illegal) begin
        exp_q.push_back({1'b1, req_tag, 64'd0});
      end else if (acc) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_rs1  = req_rs1;
        m_rs2  = req_rs2;
        m_rs3  = req_rs3;
        m_insn = 7'b1000000 >> req_op;
        m_pw   = (req_op == 3'd1) ? (5'b10000 >> req_pw_single) : 5'b00001;
        m_cl   = req_carryless && (req_op <= 3'd1);
        m_lhs  = req_lhs_sign && !m_cl;
        m_rhs  = req_rhs_sign && !m_cl;
        m_drem = req_drem_unsigned;
        m_tag  = req_tag;
      end else if (m_busy) begin
        if (done) begin
          exp_q.push_back({1'b0, m_tag, malu_result_1, malu_result_0});
          m_busy = 1'b0;
        end else if (req_kill) begin
          m_busy = 1'b0;
        end else if (tmo) begin
          exp_q.push_back({1'b1, m_tag, 64'd0});
          m_busy = 1'b0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] malu_calc(input logic [2:0] op, input logic [31:0] a, b, c);
    case (op)
      3'd0:    malu_calc = {32'd0, a} * {32'd0, b};
      3'd2:    malu_calc = (b == 32'd0) ? {32'd0, 32'hFFFFFFFF} : {32'd0, a / b};
      default: malu_calc = {a ^ c, b + 32'd1};
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [2:0] op, input logic [31:0] a, b, c, input logic [2:0] pw,
                          input logic lhs, rhs, drem, cl, input logic [TAG_W-1:0] tag);
    bit ok = 0;
    req_valid = 1; req_op = op; req_rs1 = a; req_rs2 = b; req_rs3 = c; req_pw_single = pw;
    req_lhs_sign = lhs; req_rhs_sign = rhs; req_drem_unsigned = drem; req_carryless = cl;
    req_tag = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) begin ok = 1; break; end
      tick();
    end
    tick();
    req_valid = 0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_req: req_ready stayed 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic malu_respond(input logic [2:0] op, input int delay);
    bit ok = 0;
    for (int i = 0; i < delay; i++) tick();
    malu_ready = 1;
    {malu_result_1, malu_result_0} = malu_calc(op, malu_rs1, malu_rs2, malu_rs3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (malu_flush) ok = 1;
      tick();
      if (ok) break;
    end
    malu_ready = 0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL malu_respond: malu_flush stayed 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 200 && rsp_cnt < target; i++) tick();
    if (rsp_cnt < target) begin
      n_tests++; n_fail++;
      $display("FAIL wait_rsp: responses %0d expected %0d", rsp_cnt, target);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0, f0, cyc;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs",
          128'({req_ready, malu_valid, malu_flush, rsp_valid, rsp_err, malu_pw, rsp_hi, rsp_lo, malu_rs1}),
          128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0}));
    check("reset_state", 128'(state_dbg), 128'(ST_IDLE));
    reset = 0;
    tick();

    // MUL unsigned, ready after 3 cycles
    n0 = rsp_cnt; f0 = flush_cnt;
    send_req(3'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 3'd0, 0, 0, 0, 0, 5'h15);
    check("mul_valid_next_cycle", 128'(malu_valid), 128'(1));
    malu_respond(3'd0, 3);
    wait_rsp(n0 + 1);
    check("mul_single_flush", 128'(flush_cnt - f0), 128'(1));
    check("mul_result", 128'(last_rsp), 128'({1'b0, 5'h15, 32'h00000001, 32'hFFFFFFFE}));

    // DIV by zero
    n0 = rsp_cnt;
    send_req(3'd2, 32'd100, 32'd0, 32'd0, 3'd0, 0, 0, 0, 0, 5'd3);
    check("div_insn_pw", 128'({malu_insn_div, malu_pw}), 128'({1'b1, 5'b00001}));
    malu_respond(3'd2, 1);
    wait_rsp(n0 + 1);
    check("div_by_zero", 128'(last_rsp), 128'({1'b0, 5'd3, 32'h0, 32'hFFFFFFFF}));

    // PMUL carryless with signed lhs
    n0 = rsp_cnt;
    send_req(3'd1, 32'h1234, 32'h5678, 32'd0, 3'd2, 1, 1, 0, 1, 5'd7);
    check("pmul_cl_controls",
          128'({malu_pw, malu_carryless, malu_lhs_sign, malu_rhs_sign, malu_insn_pmul}),
          128'({5'b00100, 1'b1, 1'b0, 1'b0, 1'b1}));
    malu_respond(3'd1, 0);
    wait_rsp(n0 + 1);
    check("pmul_result", 128'(last_rsp), 128'({1'b0, 5'd7, 32'h1234, 32'h5679}));

    // illegal PMUL width
    send_req(3'd1, 32'd1, 32'd2, 32'd3, 3'd5, 0, 0, 0, 0, 5'd9);
    check("illegal_rsp",
          128'({malu_valid, rsp_valid, rsp_err, rsp_tag, rsp_hi, rsp_lo}),
          128'({1'b0, 1'b1, 1'b1, 5'd9, 32'd0, 32'd0}));
    tick();

    // back-pressure: A buffered, B completes only once A drains
    rsp_ready = 0;
    send_req(3'd0, 32'd3, 32'd5, 32'd0, 3'd0, 0, 0, 0, 0, 5'd1);
    malu_respond(3'd0, 0);
    send_req(3'd0, 32'd7, 32'd9, 32'd0, 3'd0, 0, 0, 1, 0, 5'd2);
    malu_ready = 1;
    {malu_result_1, malu_result_0} = malu_calc(3'd0, malu_rs1, malu_rs2, malu_rs3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("blocked_hold", 128'({malu_valid, malu_flush, rsp_tag, rsp_lo}),
            128'({1'b1, 1'b0, 5'd1, 32'd15}));
      tick();
    end
    n0 = rsp_cnt;
    rsp_ready = 1;
    @(negedge clock);
    check("drain_and_complete", 128'(malu_flush), 128'(1));
    tick();
    malu_ready = 0;
    wait_rsp(n0 + 2);
    check("b_intact", 128'(last_rsp), 128'({1'b0, 5'd2, 32'd0, 32'd63}));

    // illegal request while the buffer is full must wait for the drain
    rsp_ready = 0;
    send_req(3'd1, 32'd0, 32'd0, 32'd0, 3'd6, 0, 0, 0, 0, 5'd10);
    req_valid = 1; req_op = 3'd1; req_pw_single = 3'd7; req_tag = 5'd11;
    @(negedge clock);
    check("illegal_blocked", 128'(req_ready), 128'(0));
    tick();
    n0 = rsp_cnt;
    rsp_ready = 1;
    @(negedge clock);
    check("illegal_unblocked", 128'(req_ready), 128'(1));
    tick();
    req_valid = 0;
    wait_rsp(n0 + 2);
    check("illegal_second", 128'(last_rsp), 128'({1'b1, 5'd11, 64'd0}));

    // kill in the same cycle as malu_ready
    n0 = rsp_cnt; f0 = flush_cnt;
    send_req(3'd3, 32'd50, 32'd7, 32'd0, 3'd0, 1, 1, 0, 0, 5'd12);
    tick();
    malu_ready = 1; req_kill = 1;
    {malu_result_1, malu_result_0} = 64'hDEAD_BEEF_0000_0001;
    @(negedge clock);
    check("kill_flush", 128'(malu_flush), 128'(1));
    tick();
    malu_ready = 0; req_kill = 0;
    @(negedge clock);
    check("kill_idle", 128'({req_ready, malu_valid}), 128'({1'b1, 1'b0}));
    tick();
    req_kill = 1;
    repeat (2) tick();
    req_kill = 0;
    tick();
    check("kill_no_rsp", 128'({rsp_cnt - n0, flush_cnt - f0}), 128'({32'd0, 32'd1}));

    // remaining ops, carryless requested but only honoured on MUL/PMUL
    for (int i = 0; i < 4; i++) begin
      logic [2:0] op;
      op = 3'(3 + i);
      n0 = rsp_cnt;
      send_req(op, 32'h1000 + 32'(i), 32'hA5A5_0000 + 32'(i), 32'h0F0F_0F0F, 3'(i), i[0], i[1], 1, 1, 5'(20 + i));
      malu_respond(op, i);
      wait_rsp(n0 + 1);
    end

    // reset mid-operation with a response buffered
    rsp_ready = 0;
    send_req(3'd1, 32'd0, 32'd0, 32'd0, 3'd7, 0, 0, 0, 0, 5'd30);
    send_req(3'd0, 32'd4, 32'd4, 32'd0, 3'd0, 0, 0, 0, 0, 5'd31);
    #2 reset = 1;
    #1;
    check("async_reset", 128'({malu_valid, rsp_valid, req_ready}), 128'({1'b0, 1'b0, 1'b1}));
    @(posedge clock);
    #1;
    reset = 0;
    rsp_ready = 1;
    tick();

`ifdef XC_MALU_ISSUER_TIMEOUT_EN
    send_req(3'd0, 32'd1, 32'd1, 32'd0, 3'd0, 0, 0, 0, 0, 5'd13);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rsp_valid) break;
      cyc++;
      tick();
    end
    check("timeout_latency", 128'(cyc), 128'(64));
    check("timeout_rsp", 128'({rsp_err, rsp_tag, rsp_hi, rsp_lo}), 128'({1'b1, 5'd13, 64'd0}));
    tick();
`else
    cyc = 0;
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
